// File: rtl/reg_file_rename_if.sv
// reg_file_rename_if: issue, commit, flush and operand-read signals of the renaming register file
interface reg_file_rename_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int Q_WIDTH = 4
);
  logic issue_en;
  logic [REG_ADDR_WIDTH-1:0] issue_rd;
  logic [Q_WIDTH-1:0] issue_Q;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr;
  logic rs1_busy;
  logic [Q_WIDTH-1:0] rs1_Q;
  logic [31:0] rs1_V;
  logic rs2_busy;
  logic [Q_WIDTH-1:0] rs2_Q;
  logic [31:0] rs2_V;
  logic commit_en;
  logic [REG_ADDR_WIDTH-1:0] commit_reg_addr;
  logic [Q_WIDTH-1:0] commit_Q;
  logic [31:0] commit_V;
  logic flush;
  modport master (
    output issue_en, issue_rd, issue_Q, rs1_addr, rs2_addr,
    output commit_en, commit_reg_addr, commit_Q, commit_V, flush,
    input rs1_busy, rs1_Q, rs1_V, rs2_busy, rs2_Q, rs2_V
  );
  modport slave (
    input issue_en, issue_rd, issue_Q, rs1_addr, rs2_addr,
    input commit_en, commit_reg_addr, commit_Q, commit_V, flush,
    output rs1_busy, rs1_Q, rs1_V, rs2_busy, rs2_Q, rs2_V
  );
endinterface

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register ROB rename tags and commit bypass
module reg_file_rename #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int Q_WIDTH = 4
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  reg_file_rename_if.slave bus
);
  localparam int N = 2 ** REG_ADDR_WIDTH;
  logic [31:0] v [N];
  logic [Q_WIDTH-1:0] q [N];
  logic [N-1:0] busy;
  logic commit_ok, issue_ok, byp1, byp2;
  assign commit_ok = bus.commit_en && bus.commit_reg_addr != '0;
  assign issue_ok = bus.issue_en && bus.issue_rd != '0;
  // later assignments win: flush/issue override the commit's busy clear
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      for (int i = 0; i < N; i++) begin
        v[i] <= '0;
        q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (commit_ok) begin
        v[bus.commit_reg_addr] <= bus.commit_V;
        if (busy[bus.commit_reg_addr] && q[bus.commit_reg_addr] == bus.commit_Q)
          busy[bus.commit_reg_addr] <= 1'b0;
      end
      if (bus.flush) busy <= '0;
      else if (issue_ok) begin
        busy[bus.issue_rd] <= 1'b1;
        q[bus.issue_rd] <= bus.issue_Q;
      end
    end
  end
  // a commit resolving the current rename is forwarded to readers in the same cycle
  assign byp1 = commit_ok && busy[bus.rs1_addr] && bus.commit_reg_addr == bus.rs1_addr && bus.commit_Q == q[bus.rs1_addr];
  assign byp2 = commit_ok && busy[bus.rs2_addr] && bus.commit_reg_addr == bus.rs2_addr && bus.commit_Q == q[bus.rs2_addr];
  assign bus.rs1_busy = bus.rs1_addr != '0 && busy[bus.rs1_addr] && !byp1;
  assign bus.rs1_Q = bus.rs1_addr == '0 ? '0 : q[bus.rs1_addr];
  assign bus.rs1_V = bus.rs1_addr == '0 ? 32'd0 : byp1 ? bus.commit_V : v[bus.rs1_addr];
  assign bus.rs2_busy = bus.rs2_addr != '0 && busy[bus.rs2_addr] && !byp2;
  assign bus.rs2_Q = bus.rs2_addr == '0 ? '0 : q[bus.rs2_addr];
  assign bus.rs2_V = bus.rs2_addr == '0 ? 32'd0 : byp2 ? bus.commit_V : v[bus.rs2_addr];
endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename: directed scenarios plus randomized traffic against a register-array reference model
module tb_reg_file_rename;
  localparam int A = 5;
  localparam int QW = 4;
  localparam int N = 2 ** A;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  int checks = 0;
  int errors = 0;
  reg_file_rename_if #(.REG_ADDR_WIDTH(A), .Q_WIDTH(QW)) bus ();
  reg_file_rename #(.REG_ADDR_WIDTH(A), .Q_WIDTH(QW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus)
  );
  always #5 clk_in = ~clk_in;

  logic [31:0] m_v [N];
  logic [QW-1:0] m_q [N];
  bit m_busy [N];

  task automatic model_edge();
    int c, d;
    c = int'(bus.commit_reg_addr);
    d = int'(bus.issue_rd);
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        m_v[i] = 0; m_q[i] = 0; m_busy[i] = 0;
      end
    end else if (rdy_in) begin
      if (bus.commit_en && c != 0) begin
        m_v[c] = bus.commit_V;
        if (m_busy[c] && m_q[c] == bus.commit_Q) m_busy[c] = 0;
      end
      if (bus.flush) for (int i = 0; i < N; i++) m_busy[i] = 0;
      else if (bus.issue_en && d != 0) begin
        m_busy[d] = 1; m_q[d] = bus.issue_Q;
      end
    end
  endtask

  task automatic model_read(input int a, output bit b, output logic [QW-1:0] qq, output logic [31:0] vv);
    b = 0; qq = 0; vv = 0;
    if (a != 0) begin
      if (m_busy[a] && bus.commit_en && int'(bus.commit_reg_addr) == a && bus.commit_Q == m_q[a]) vv = bus.commit_V;
      else begin
        b = m_busy[a]; qq = m_q[a]; vv = m_v[a];
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.issue_en = 0; bus.issue_rd = 0; bus.issue_Q = 0;
    bus.commit_en = 0; bus.commit_reg_addr = 0; bus.commit_Q = 0; bus.commit_V = 0;
    bus.flush = 0;
  endtask

  task automatic test_reset();
    idle(); bus.rs1_addr = 0; bus.rs2_addr = 0;
    rst_in = 1; tick(); rst_in = 0;
    bus.rs1_addr = 5; bus.rs2_addr = 0; #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy got %b exp 0", bus.rs1_busy); end
    checks++; if (bus.rs1_V !== 32'd0) begin errors++; $display("FAIL reset_rs1_V got %h exp 0", bus.rs1_V); end
    checks++; if (bus.rs1_Q !== 4'd0) begin errors++; $display("FAIL reset_rs1_Q got %h exp 0", bus.rs1_Q); end
    checks++; if (bus.rs2_busy !== 1'b0 || bus.rs2_V !== 32'd0) begin errors++; $display("FAIL reset_rs2 got busy=%b V=%h exp 0/0", bus.rs2_busy, bus.rs2_V); end
  endtask

  task automatic test_bypass();
    idle(); bus.issue_en = 1; bus.issue_rd = 5; bus.issue_Q = 3; tick();
    idle(); bus.rs1_addr = 5; #1;
    checks++; if (bus.rs1_busy !== 1'b1 || bus.rs1_Q !== 4'd3) begin errors++; $display("FAIL issue_x5 got busy=%b Q=%h exp 1/3", bus.rs1_busy, bus.rs1_Q); end
    bus.commit_en = 1; bus.commit_reg_addr = 5; bus.commit_Q = 3; bus.commit_V = 32'hDEADBEEF; #1;
    checks++; if (bus.rs1_busy !== 1'b0 || bus.rs1_V !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_x5 got busy=%b V=%h exp 0/deadbeef", bus.rs1_busy, bus.rs1_V); end
    tick(); idle(); #1;
    checks++; if (bus.rs1_busy !== 1'b0 || bus.rs1_V !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_x5 got busy=%b V=%h exp 0/deadbeef", bus.rs1_busy, bus.rs1_V); end
  endtask

  task automatic test_younger_rename();
    idle(); bus.issue_en = 1; bus.issue_rd = 7; bus.issue_Q = 2; tick();
    bus.issue_Q = 4; tick();
    idle(); bus.commit_en = 1; bus.commit_reg_addr = 7; bus.commit_Q = 2; bus.commit_V = 32'h11; bus.rs1_addr = 7; #1;
    checks++; if (bus.rs1_busy !== 1'b1 || bus.rs1_Q !== 4'd4) begin errors++; $display("FAIL stale_commit_nobypass got busy=%b Q=%h exp 1/4", bus.rs1_busy, bus.rs1_Q); end
    tick(); idle(); #1;
    checks++; if (bus.rs1_busy !== 1'b1 || bus.rs1_Q !== 4'd4) begin errors++; $display("FAIL stale_commit got busy=%b Q=%h exp 1/4", bus.rs1_busy, bus.rs1_Q); end
    bus.commit_en = 1; bus.commit_reg_addr = 7; bus.commit_Q = 4; bus.commit_V = 32'h22; tick(); idle(); #1;
    checks++; if (bus.rs1_busy !== 1'b0 || bus.rs1_V !== 32'h22) begin errors++; $display("FAIL young_commit got busy=%b V=%h exp 0/22", bus.rs1_busy, bus.rs1_V); end
  endtask

  task automatic test_same_cycle();
    idle(); bus.issue_en = 1; bus.issue_rd = 9; bus.issue_Q = 5; tick();
    bus.issue_Q = 6; bus.commit_en = 1; bus.commit_reg_addr = 9; bus.commit_Q = 5; bus.commit_V = 32'h55;
    bus.rs2_addr = 9; #1;
    checks++; if (bus.rs2_busy !== 1'b0 || bus.rs2_V !== 32'h55) begin errors++; $display("FAIL same_cycle_bypass got busy=%b V=%h exp 0/55", bus.rs2_busy, bus.rs2_V); end
    tick(); idle(); #1;
    checks++; if (bus.rs2_busy !== 1'b1 || bus.rs2_Q !== 4'd6) begin errors++; $display("FAIL same_cycle_issue_wins got busy=%b Q=%h exp 1/6", bus.rs2_busy, bus.rs2_Q); end
    bus.flush = 1; tick(); idle(); #1;
    checks++; if (bus.rs2_busy !== 1'b0 || bus.rs2_V !== 32'h55) begin errors++; $display("FAIL same_cycle_V got busy=%b V=%h exp 0/55", bus.rs2_busy, bus.rs2_V); end
  endtask

  task automatic test_flush();
    idle(); bus.issue_en = 1;
    for (int r = 1; r <= 3; r++) begin
      bus.issue_rd = A'(r); bus.issue_Q = QW'(r); tick();
    end
    bus.issue_rd = 4; bus.issue_Q = 1; bus.flush = 1;
    bus.commit_en = 1; bus.commit_reg_addr = 2; bus.commit_Q = 2; bus.commit_V = 32'hAB; tick();
    idle(); bus.rs1_addr = 1; bus.rs2_addr = 2; #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL flush_x1 got busy=%b exp 0", bus.rs1_busy); end
    checks++; if (bus.rs2_busy !== 1'b0 || bus.rs2_V !== 32'hAB) begin errors++; $display("FAIL flush_x2 got busy=%b V=%h exp 0/ab", bus.rs2_busy, bus.rs2_V); end
    bus.rs1_addr = 3; bus.rs2_addr = 4; #1;
    checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL flush_x3_x4 got busy=%b/%b exp 0/0", bus.rs1_busy, bus.rs2_busy); end
  endtask

  task automatic test_x0_rdy();
    idle(); bus.issue_en = 1; bus.issue_rd = 0; bus.issue_Q = 7;
    bus.commit_en = 1; bus.commit_reg_addr = 0; bus.commit_Q = 0; bus.commit_V = 32'h99; bus.rs1_addr = 0; #1;
    checks++; if (bus.rs1_busy !== 1'b0 || bus.rs1_V !== 32'd0) begin errors++; $display("FAIL x0_live got busy=%b V=%h exp 0/0", bus.rs1_busy, bus.rs1_V); end
    tick(); idle(); #1;
    checks++; if (bus.rs1_busy !== 1'b0 || bus.rs1_V !== 32'd0 || bus.rs1_Q !== 4'd0) begin errors++; $display("FAIL x0_state got busy=%b Q=%h V=%h exp 0/0/0", bus.rs1_busy, bus.rs1_Q, bus.rs1_V); end
    rdy_in = 0; bus.issue_en = 1; bus.issue_rd = 6; bus.issue_Q = 5; bus.flush = 0; tick();
    bus.issue_en = 0; bus.issue_rd = 9; bus.flush = 1; tick();
    rdy_in = 1; idle(); bus.rs1_addr = 6; bus.rs2_addr = 9; #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL rdy_low_issue got busy=%b exp 0", bus.rs1_busy); end
    checks++; if (bus.rs2_busy !== 1'b0 || bus.rs2_V !== 32'h55) begin errors++; $display("FAIL rdy_low_x9 got busy=%b V=%h exp 0/55", bus.rs2_busy, bus.rs2_V); end
  endtask

  task automatic test_random();
    bit eb;
    logic [QW-1:0] eq;
    logic [31:0] ev;
    for (int n = 0; n < 400; n++) begin
      rdy_in = $urandom_range(9) != 0;
      bus.issue_en = $urandom_range(1); bus.issue_rd = A'($urandom_range(7)); bus.issue_Q = QW'($urandom);
      bus.commit_en = $urandom_range(1); bus.commit_reg_addr = A'($urandom_range(7));
      bus.commit_Q = ($urandom_range(1) != 0) ? m_q[int'(bus.commit_reg_addr)] : QW'($urandom);
      bus.commit_V = $urandom; bus.flush = $urandom_range(15) == 0;
      bus.rs1_addr = A'($urandom_range(7));
      bus.rs2_addr = ($urandom_range(1) != 0) ? bus.commit_reg_addr : A'($urandom_range(7));
      #1;
      model_read(int'(bus.rs1_addr), eb, eq, ev);
      checks++;
      if (bus.rs1_busy !== eb || (eb && bus.rs1_Q !== eq) || (!eb && bus.rs1_V !== ev)) begin
        errors++; $display("FAIL rand_rs1 n=%0d x%0d got busy=%b Q=%h V=%h exp %b/%h/%h", n, bus.rs1_addr, bus.rs1_busy, bus.rs1_Q, bus.rs1_V, eb, eq, ev);
      end
      model_read(int'(bus.rs2_addr), eb, eq, ev);
      checks++;
      if (bus.rs2_busy !== eb || (eb && bus.rs2_Q !== eq) || (!eb && bus.rs2_V !== ev)) begin
        errors++; $display("FAIL rand_rs2 n=%0d x%0d got busy=%b Q=%h V=%h exp %b/%h/%h", n, bus.rs2_addr, bus.rs2_busy, bus.rs2_Q, bus.rs2_V, eb, eq, ev);
      end
      tick();
    end
    rdy_in = 1; idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_younger_rename();
    test_same_cycle();
    test_flush();
    test_x0_rdy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_rename.md
# reg_file_rename

Architectural register file with per-register rename tags, directly downstream of the reorder buffer's commit port and beside the issue stage. It holds 32 committed values. For each register it tracks whether an in-flight ROB entry will produce the value and which ROB slot (Q) that is. Issue reads operands and tags from it, commit writes values into it, and a ROB control-hazard flush discards all pending renames in one cycle.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width (2**REG_ADDR_WIDTH registers).
- Q_WIDTH, 4, ROB slot tag width.

Ports:
- clk_in  input  1  single clock; all state updates on posedge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global enable; low freezes all state.
- issue_en  input  1  issue stage is renaming a destination this cycle.
- issue_rd  input  REG_ADDR_WIDTH  destination register being renamed.
- issue_Q  input  Q_WIDTH  ROB slot allocated to that destination (the ROB tail).
- rs1_addr  input  REG_ADDR_WIDTH  operand 1 register index.
- rs2_addr  input  REG_ADDR_WIDTH  operand 2 register index.
- rs1_busy  output  1  operand 1 is waiting on a ROB entry.
- rs1_Q  output  Q_WIDTH  ROB slot producing operand 1; meaningful only when rs1_busy=1.
- rs1_V  output  32  operand 1 value; meaningful only when rs1_busy=0.
- rs2_busy, rs2_Q, rs2_V  output  1/Q_WIDTH/32  operand 2, same semantics as operand 1.
- commit_en  input  1  ROB commit modifies the register file (commit_modify_regfile).
- commit_reg_addr  input  REG_ADDR_WIDTH  committed destination.
- commit_Q  input  Q_WIDTH  ROB slot being committed.
- commit_V  input  32  committed value.
- flush  input  1  ROB control hazard; discard all renames.

## Operation
- State per register r: V[r] (32b), busy[r] (1b), Q[r] (Q_WIDTH).
- Register 0: reads V=0, busy=0, Q=0 always. Issue and commit to r0 are ignored.
- Commit (commit_en=1, rd≠0): V[rd] <= commit_V unconditionally. busy[rd] <= 0 only if busy[rd]=1 and Q[rd]==commit_Q. A tag mismatch means a younger rename exists, so busy and Q are unchanged.
- Issue (issue_en=1, rd≠0): busy[rd] <= 1, Q[rd] <= issue_Q.
- Issue and commit to the same rd in the same cycle: V takes commit_V, busy stays 1, Q takes issue_Q. Issue wins on tag and busy.
- Flush=1: all busy <= 0 next edge. Q contents are don't-care. A concurrent issue is dropped. A concurrent commit still writes V and clears busy as normal.
- Read port (combinational), for rsX:
  - If rsX=0, output busy=0, V=0.
  - Else if busy[rsX] and commit_en and commit_reg_addr==rsX and commit_Q==Q[rsX], output busy=0, V=commit_V (commit bypass).
  - Else output busy[rsX], Q[rsX], V[rsX].
- Reads never see a same-cycle issue. An instruction with rs==rd gets the old mapping.

## Timing
- Reads are combinational, with zero latency from the rs*_addr and commit inputs.
- Writes from issue, commit and flush become visible to reads one cycle later, except the commit bypass, which is visible the same cycle.
- Reset (rst_in=1 at posedge): all V=0, busy=0, Q=0. From the next cycle every read returns busy=0, Q=0, V=0. Reset overrides flush, issue and commit.
- rdy_in=0: no state change, including flush. Reads and the commit bypass remain live.
- Priority per register per edge: reset > flush (busy) > issue (busy, Q) > commit (busy clear). V writes only from commit.
- No handshake. Inputs are single-cycle strobes sampled at every enabled edge.

## Test plan
- Reset, then read rs1=5, rs2=0: both return busy=0, V=0.
- Issue x5 to Q=3. Next cycle rs1=5 gives busy=1, Q=3. Commit x5/Q=3/V=0xDEADBEEF: same cycle gives busy=0, V=DEADBEEF (bypass). Next cycle gives the same from state.
- Issue x7→Q=2, then x7→Q=4. Commit x7/Q=2/V=0x11: busy stays 1, Q=4, V[7]=0x11. Commit x7/Q=4/V=0x22: busy=0, V=0x22.
- Same cycle: issue x9→Q=6 and commit x9/Q=5/V=0x55 with x9 busy Q=5. Next cycle: busy=1, Q=6, V[9]=0x55.
- Busy x1..x3, then flush with concurrent issue x4→Q=1 and commit x2. Next cycle: x1..x4 all busy=0. x2 holds the committed V.
- Issue/commit to x0 with V=0x99: x0 reads busy=0, V=0. With rdy_in=0, issue x6: no change.
